// File: rtl/jelly_vsync_adjust_de_ext_pkg.sv
// Shared helpers for the vsync-adjust DE generator.
package jelly_vsync_adjust_de_ext_pkg;

    // Sideband ports keep one dummy bit when no user data is carried.
    function automatic int user_bits(input int width);
        return (width > 0) ? width : 1;
    endfunction

endpackage

// File: rtl/jelly_vsync_adjust_de_ext_axis_cnt.sv
// One timing axis: saturating position counter plus active-window compare.
module jelly_vsync_adjust_de_ext_axis_cnt #(
    parameter int WIDTH = 14
)(
    input  logic             reset,
    input  logic             clk,
    input  logic             clear,
    input  logic             step,
    input  logic [WIDTH-1:0] param_start,
    input  logic [WIDTH-1:0] param_size,
    output logic [WIDTH-1:0] count_prev,
    output logic             de
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH:0]   stop_sum;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (step && (count_reg != {WIDTH{1'b1}})) begin
            count_next = count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Window end is one bit wider so start+size never wraps back into range.
    assign stop_sum = {1'b0, param_start} + {1'b0, param_size};
    assign de       = (count_next >= param_start) && ({1'b0, count_next} < stop_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_prev = count_reg;

endmodule

// File: rtl/jelly_vsync_adjust_de_ext.sv
// Regenerates DE from vsync/hsync with shadowed H/V windows, polarity select,
// htotal/vtotal measurement, a vsync watchdog and a LATENCY-deep output pipeline.
module jelly_vsync_adjust_de_ext
    import jelly_vsync_adjust_de_ext_pkg::*;
#(
    parameter int USER_WIDTH    = 0,
    parameter int H_COUNT_WIDTH = 14,
    parameter int V_COUNT_WIDTH = 14,
    parameter int LATENCY       = 2,
    parameter int TIMEOUT_WIDTH = 24
)(
    input  logic                              reset,
    input  logic                              clk,
    input  logic                              enable,
    output logic                              busy,
    input  logic [H_COUNT_WIDTH-1:0]          param_hsize,
    input  logic [V_COUNT_WIDTH-1:0]          param_vsize,
    input  logic [H_COUNT_WIDTH-1:0]          param_hstart,
    input  logic [V_COUNT_WIDTH-1:0]          param_vstart,
    input  logic                              param_hpol,
    input  logic                              param_vpol,
    input  logic                              update_req,
    output logic                              update_ack,
    input  logic [TIMEOUT_WIDTH-1:0]          timeout_limit,
    output logic                              timeout,
    output logic [H_COUNT_WIDTH-1:0]          meas_htotal,
    output logic [V_COUNT_WIDTH-1:0]          meas_vtotal,
    input  logic                              in_vsync,
    input  logic                              in_hsync,
    input  logic [user_bits(USER_WIDTH)-1:0]  in_user,
    output logic                              out_vsync,
    output logic                              out_hsync,
    output logic                              out_de,
    output logic [user_bits(USER_WIDTH)-1:0]  out_user
);

    localparam int USER_BITS = user_bits(USER_WIDTH);

    logic                     vs_reg, hs_reg, vs_prev_reg, hs_prev_reg;
    logic                     frame_start, line_start, take;
    logic [H_COUNT_WIDTH-1:0] sh_hsize_reg, sh_hstart_reg, eff_hsize, eff_hstart;
    logic [V_COUNT_WIDTH-1:0] sh_vsize_reg, sh_vstart_reg, eff_vsize, eff_vstart;
    logic                     sh_hpol_reg, sh_vpol_reg;
    logic                     enable_reg, en_now, de_now, h_de, v_de;
    logic [H_COUNT_WIDTH-1:0] h_prev, meas_htotal_reg;
    logic [V_COUNT_WIDTH-1:0] v_prev, meas_vtotal_reg;
    logic                     seen_line_reg, seen_frame_reg;
    logic                     update_ack_reg, timeout_reg;
    logic [TIMEOUT_WIDTH-1:0] wd_reg, wd_next;
    logic                     wd_hit, timeout_set;

    assign frame_start = vs_reg & ~vs_prev_reg;
    assign line_start  = hs_reg & ~hs_prev_reg;
    assign take        = frame_start & update_req;

    // A frame start that takes an update already uses the new window for its first pixel.
    assign eff_hsize  = take ? param_hsize  : sh_hsize_reg;
    assign eff_hstart = take ? param_hstart : sh_hstart_reg;
    assign eff_vsize  = take ? param_vsize  : sh_vsize_reg;
    assign eff_vstart = take ? param_vstart : sh_vstart_reg;

    jelly_vsync_adjust_de_ext_axis_cnt #(.WIDTH(H_COUNT_WIDTH)) u_h_axis (
        .reset       (reset),
        .clk         (clk),
        .clear       (line_start),
        .step        (1'b1),
        .param_start (eff_hstart),
        .param_size  (eff_hsize),
        .count_prev  (h_prev),
        .de          (h_de)
    );

    // Frame start has priority, so a coincident line start becomes line 0.
    jelly_vsync_adjust_de_ext_axis_cnt #(.WIDTH(V_COUNT_WIDTH)) u_v_axis (
        .reset       (reset),
        .clk         (clk),
        .clear       (frame_start),
        .step        (line_start),
        .param_start (eff_vstart),
        .param_size  (eff_vsize),
        .count_prev  (v_prev),
        .de          (v_de)
    );

    always_comb begin
        wd_next = wd_reg;
        if (frame_start) begin
            wd_next = '0;
        end else if (!wd_hit && (wd_reg != {TIMEOUT_WIDTH{1'b1}})) begin
            wd_next = wd_reg + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign wd_hit      = (timeout_limit != '0) && (wd_reg >= timeout_limit);
    assign timeout_set = !frame_start && (timeout_limit != '0) && (wd_next >= timeout_limit);
    assign en_now      = frame_start ? enable : (enable_reg & ~timeout_set);
    assign de_now      = en_now & h_de & v_de;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_reg          <= 1'b0;
            hs_reg          <= 1'b0;
            vs_prev_reg     <= 1'b0;
            hs_prev_reg     <= 1'b0;
            sh_hsize_reg    <= '0;
            sh_hstart_reg   <= '0;
            sh_vsize_reg    <= '0;
            sh_vstart_reg   <= '0;
            sh_hpol_reg     <= 1'b0;
            sh_vpol_reg     <= 1'b0;
            enable_reg      <= 1'b0;
            update_ack_reg  <= 1'b0;
            timeout_reg     <= 1'b0;
            wd_reg          <= '0;
            seen_line_reg   <= 1'b0;
            seen_frame_reg  <= 1'b0;
            meas_htotal_reg <= '0;
            meas_vtotal_reg <= '0;
        end else begin
            vs_reg         <= in_vsync ^ sh_vpol_reg;
            hs_reg         <= in_hsync ^ sh_hpol_reg;
            vs_prev_reg    <= vs_reg;
            hs_prev_reg    <= hs_reg;
            wd_reg         <= wd_next;
            enable_reg     <= en_now;
            update_ack_reg <= take;
            timeout_reg    <= frame_start ? 1'b0 : (timeout_reg | timeout_set);
            if (take) begin
                sh_hsize_reg  <= param_hsize;
                sh_hstart_reg <= param_hstart;
                sh_vsize_reg  <= param_vsize;
                sh_vstart_reg <= param_vstart;
                sh_hpol_reg   <= param_hpol;
                sh_vpol_reg   <= param_vpol;
            end
            // The first edge after reset has no complete period behind it.
            if (line_start) begin
                seen_line_reg <= 1'b1;
                if (seen_line_reg) begin
                    meas_htotal_reg <= h_prev + {{(H_COUNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            if (frame_start) begin
                seen_frame_reg <= 1'b1;
                if (seen_frame_reg) begin
                    meas_vtotal_reg <= v_prev + {{(V_COUNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_sync_dly
            logic                 vs_q;
            logic                 hs_q;
            logic [USER_BITS-1:0] user_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        vs_q   <= 1'b0;
                        hs_q   <= 1'b0;
                        user_q <= '0;
                    end else begin
                        vs_q   <= in_vsync;
                        hs_q   <= in_hsync;
                        user_q <= in_user;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        vs_q   <= 1'b0;
                        hs_q   <= 1'b0;
                        user_q <= '0;
                    end else begin
                        vs_q   <= g_sync_dly[gi-1].vs_q;
                        hs_q   <= g_sync_dly[gi-1].hs_q;
                        user_q <= g_sync_dly[gi-1].user_q;
                    end
                end
            end
        end

        // DE is formed one stage in, so it needs one register fewer than the syncs.
        for (gi = 0; gi < LATENCY - 1; gi++) begin : g_de_dly
            logic de_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        de_q <= 1'b0;
                    end else begin
                        de_q <= de_now;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        de_q <= 1'b0;
                    end else begin
                        de_q <= g_de_dly[gi-1].de_q;
                    end
                end
            end
        end
    endgenerate

    assign out_vsync   = g_sync_dly[LATENCY-1].vs_q;
    assign out_hsync   = g_sync_dly[LATENCY-1].hs_q;
    assign out_user    = g_sync_dly[LATENCY-1].user_q;
    assign out_de      = g_de_dly[LATENCY-2].de_q;
    assign busy        = enable_reg & vs_reg;
    assign update_ack  = update_ack_reg;
    assign timeout     = timeout_reg;
    assign meas_htotal = meas_htotal_reg;
    assign meas_vtotal = meas_vtotal_reg;

endmodule
